// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared constants for the complement unit: the FSM state encoding and the
// conv_mode code values. Imported by complement_unit_param.
// No ports.
// -----------------------------------------------------------------------------
package calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_CONV_A = 2'b01,
      ST_CONV_B = 2'b10,
      ST_DONE   = 2'b11
   } state_t;

   localparam logic [1:0] MODE_PASS = 2'b00;  // operand passed unchanged
   localparam logic [1:0] MODE_NEG  = 2'b01;  // two's-complement negate
   localparam logic [1:0] MODE_SM   = 2'b10;  // sign-magnitude -> two's complement
   localparam logic [1:0] MODE_RSV  = 2'b11;  // reserved, behaves as MODE_PASS

endpackage : calc_pkg

// File: rtl/negate_unit.sv
// -----------------------------------------------------------------------------
// negate_unit
// Combinational two's-complement negation: y = ~a + 1 (mod 2^WIDTH), with ovf
// flagging the one input whose negation is not representable (1 followed by
// WIDTH-1 zeros).
// Ports:
//   a   : input  [WIDTH-1:0]  operand
//   y   : output [WIDTH-1:0]  ~a + 1, wrapped
//   ovf : output              a is the most negative value
// -----------------------------------------------------------------------------
module negate_unit #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      y   = ~a + ONE;
      ovf = (a == MOST_NEG);
   end

endmodule : negate_unit

// File: rtl/complement_unit_param.sv
// -----------------------------------------------------------------------------
// complement_unit_param
// Loads one coded word {first, second, opcode} on an accepted start and
// converts the two operands one per cycle through a single shared negate_unit
// (IDLE -> CONV_A -> CONV_B -> DONE -> IDLE). Results, opcode and overflow
// flags are registered together on the edge entering DONE and held until the
// next completion or reset.
// Build option: define COMPLEMENT_SATURATE_EN to saturate a mode-01 overflowing
// operand to the most positive value instead of the wrapped result.
// Ports:
//   clk               : input              rising-edge clock
//   rst               : input              asynchronous reset, active low
//   start             : input              load/convert request (IDLE only)
//   nr_coded          : input  [2W+OPW-1:0] {first, second, opcode}
//   conv_mode         : input  [1:0]       00 pass, 01 negate, 10 sm->2c, 11 pass
//   first_nr          : output [W-1:0]     converted first operand
//   second_nr         : output [W-1:0]     converted second operand
//   operation         : output [OPW-1:0]   opcode passed through
//   ovf               : output [1:0]       {first, second} overflow
//   busy              : output             start accepted, DONE not yet left
//   complement_finish : output             one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module complement_unit_param
   import calc_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int OP_WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [2*WIDTH+OP_WIDTH-1:0] nr_coded,
   input  logic [1:0]                  conv_mode,
   output logic [WIDTH-1:0]            first_nr,
   output logic [WIDTH-1:0]            second_nr,
   output logic [OP_WIDTH-1:0]         operation,
   output logic [1:0]                  ovf,
   output logic                        busy,
   output logic                        complement_finish
);

   state_t                      state, state_nxt;
   logic [2*WIDTH+OP_WIDTH-1:0] code_q;
   logic [1:0]                  mode_q;
   logic signed [WIDTH-1:0]     res_a_q;
   logic                        ovf_a_q;

   logic signed [WIDTH-1:0]     opnd;
   logic [WIDTH-1:0]            neg_in;
   logic [WIDTH-1:0]            neg_out;
   logic                        neg_ovf;
   logic                        use_neg;
   logic                        ovf_cur;
   logic signed [WIDTH-1:0]     res_cur;

   // Most positive representable value, used when saturation is enabled.
   function automatic logic signed [WIDTH-1:0] sat_pos();
      return {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_CONV_A;
         ST_CONV_A: state_nxt = ST_CONV_B;
         ST_CONV_B: state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign busy              = (state != ST_IDLE);
   assign complement_finish = (state == ST_DONE);

   // Shared conversion datapath: the operand is chosen by the current state.
   // In sign-magnitude mode only the magnitude is fed to the negator, so its
   // input MSB is always 0 and its overflow can never fire; negative zero
   // negates to 0 naturally.
   always_comb begin
      opnd    = (state == ST_CONV_B) ? code_q[OP_WIDTH +: WIDTH]
                                     : code_q[OP_WIDTH+WIDTH +: WIDTH];
      neg_in  = (mode_q == MODE_SM) ? {1'b0, opnd[WIDTH-2:0]} : opnd;
      use_neg = (mode_q == MODE_NEG) || ((mode_q == MODE_SM) && opnd[WIDTH-1]);
      ovf_cur = (mode_q == MODE_NEG) && neg_ovf;
      res_cur = opnd;
      if (use_neg) begin
`ifdef COMPLEMENT_SATURATE_EN
         res_cur = ovf_cur ? sat_pos() : neg_out;
`else
         res_cur = neg_out;
`endif
      end
   end

   negate_unit #(.WIDTH(WIDTH)) u_negate (
      .a   (neg_in),
      .y   (neg_out),
      .ovf (neg_ovf)
   );

   // Input latch, first-operand holding register and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         code_q    <= '0;
         mode_q    <= '0;
         res_a_q   <= '0;
         ovf_a_q   <= 1'b0;
         first_nr  <= '0;
         second_nr <= '0;
         operation <= '0;
         ovf       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  code_q <= nr_coded;
                  mode_q <= conv_mode;
               end
            end
            ST_CONV_A: begin
               res_a_q <= res_cur;
               ovf_a_q <= ovf_cur;
            end
            ST_CONV_B: begin
               first_nr  <= res_a_q;
               second_nr <= res_cur;
               operation <= code_q[OP_WIDTH-1:0];
               ovf       <= {ovf_a_q, ovf_cur};
            end
            default: ;
         endcase
      end
   end

endmodule : complement_unit_param

// File: tb/tb_complement_unit_param.sv
// -----------------------------------------------------------------------------
// tb_complement_unit_param
// Directed and randomized stimulus for complement_unit_param (WIDTH=4,
// OP_WIDTH=4) checked against an arithmetic reference model.
// Honors COMPLEMENT_SATURATE_EN in the model when the macro is defined.
// -----------------------------------------------------------------------------
module tb_complement_unit_param;

   localparam int W  = 4;
   localparam int OW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [2*W+OW-1:0] nr_coded;
   logic [1:0]        conv_mode;
   logic [W-1:0]      first_nr, second_nr;
   logic [OW-1:0]     operation;
   logic [1:0]        ovf;
   logic              busy, complement_finish;

   int checks   = 0;
   int failures = 0;

   complement_unit_param #(.WIDTH(W), .OP_WIDTH(OW)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .nr_coded          (nr_coded),
      .conv_mode         (conv_mode),
      .first_nr          (first_nr),
      .second_nr         (second_nr),
      .operation         (operation),
      .ovf               (ovf),
      .busy              (busy),
      .complement_finish (complement_finish)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference conversion of one operand, in plain integer arithmetic.
   task automatic model(input int x, input logic [1:0] mode, output int r, output int ov);
      int modulus, half, mag;
      modulus = 1 << W;
      half    = 1 << (W - 1);
      r  = x;
      ov = 0;
      if (mode == 2'b01) begin
         r  = (modulus - x) % modulus;
         ov = (x == half) ? 1 : 0;
`ifdef COMPLEMENT_SATURATE_EN
         if (ov == 1) r = half - 1;
`endif
      end else if (mode == 2'b10) begin
         mag = x % half;
         r   = (x >= half) ? (modulus - mag) % modulus : mag;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_first"}, first_nr, 0);
      chk({tag, "_second"}, second_nr, 0);
      chk({tag, "_op"}, operation, 0);
      chk({tag, "_ovf"}, ovf, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_finish"}, complement_finish, 0);
   endtask

   task automatic check_result(input string tag, input logic [2*W+OW-1:0] code,
                               input logic [1:0] mode);
      int ra, oa, rb, ob;
      model(int'(code[W+OW +: W]), mode, ra, oa);
      model(int'(code[OW +: W]), mode, rb, ob);
      chk({tag, "_first"}, first_nr, ra);
      chk({tag, "_second"}, second_nr, rb);
      chk({tag, "_op"}, operation, code[OW-1:0]);
      chk({tag, "_ovf"}, ovf, {oa[0], ob[0]});
   endtask

   // Called at a falling edge. One full conversion, checked cycle by cycle.
   // With glitch set, a start with different data is pulsed in CONV_A.
   task automatic run_conv(input string tag, input logic [2*W+OW-1:0] code,
                           input logic [1:0] mode, input bit glitch);
      nr_coded  = code;
      conv_mode = mode;
      start     = 1'b1;
      @(negedge clk);
      chk({tag, "_a_busy"}, busy, 1);
      chk({tag, "_a_fin"}, complement_finish, 0);
      if (glitch) begin
         nr_coded  = ~code;
         conv_mode = mode ^ 2'b11;
      end else begin
         start    = 1'b0;
         nr_coded = 12'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_b_fin"}, complement_finish, 0);
      @(negedge clk);
      chk({tag, "_d_fin"}, complement_finish, 1);
      chk({tag, "_d_busy"}, busy, 1);
      check_result(tag, code, mode);
      @(negedge clk);
      chk({tag, "_i_fin"}, complement_finish, 0);
      chk({tag, "_i_busy"}, busy, 0);
      check_result({tag, "_hold"}, code, mode);
   endtask

   initial begin
      logic [2*W+OW-1:0] code;
      logic [1:0]        mode;

      rst       = 1'b0;
      start     = 1'b0;
      nr_coded  = '0;
      conv_mode = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;

      // First start right after reset release
      run_conv("neg_35A", 12'h35A, 2'b01, 1'b0);
      run_conv("neg_ovf", 12'h821, 2'b01, 1'b0);
      run_conv("neg_ovf2", 12'h38C, 2'b01, 1'b0);
      run_conv("sm_B8", 12'hB87, 2'b10, 1'b0);
      run_conv("sm_pos", 12'h5F3, 2'b10, 1'b0);
      run_conv("pass", 12'h8E9, 2'b00, 1'b0);
      run_conv("rsv", 12'hC41, 2'b11, 1'b0);
      run_conv("glitch", 12'h3A6, 2'b01, 1'b1);

      // Reset in CONV_B aborts the conversion
      nr_coded  = 12'h7E5;
      conv_mode = 2'b01;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("rst_mid");
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_nofin", complement_finish, 0);
      end
      rst = 1'b1;
      run_conv("after_rst", 12'h1F2, 2'b01, 1'b0);

      // Start held high: one conversion every 4 cycles
      code      = 12'h6B3;
      mode      = 2'b01;
      nr_coded  = code;
      conv_mode = mode;
      start     = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         chk("held_fin", complement_finish, ((e % 4) == 3) ? 1 : 0);
         if ((e % 4) == 3) check_result("held", code, mode);
      end
      start = 1'b0;
      @(negedge clk);

      // Randomized conversions
      for (int i = 0; i < 40; i++) begin
         code = 12'($urandom);
         mode = 2'($urandom_range(0, 3));
         run_conv("rand", code, mode, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_complement_unit_param
